// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared types and constants for the 5-stage core pipeline control logic.
//   fwd_sel_t  : ALU operand source select (regfile / EX / MEM / WB result)
//   hz_state_t : hazard unit FSM states
//   REG_AW_DEFAULT : default register address width
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    localparam int REG_AW_DEFAULT = 5;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2
    } hz_state_t;

endpackage

// File: rtl/fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
// Combinational priority match of one ID-stage source operand against the
// destinations tracked for the EX, MEM and WB stages.
// Ports:
//   src_i, use_src_i         : source register and its "is read" flag
//   ex_rd_i/ex_wr_i/ex_ld_i  : EX-stage destination, write enable, is-load
//   mem_rd_i/mem_wr_i        : MEM-stage destination and write enable
//   wb_rd_i/wb_wr_i          : WB-stage destination and write enable
//   ex_hit_o                 : source matches the EX destination (any kind)
//   sel_o                    : forwarding select, EX > MEM > WB > regfile
// -----------------------------------------------------------------------------
import pipeline_ctrl_pkg::*;

module fwd_select #(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic              use_src_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_wr_i,
    input  logic              ex_ld_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_wr_i,
    output logic              ex_hit_o,
    output fwd_sel_t          sel_o
);

    logic mem_hit;
    logic wb_hit;

    // x0 is hard-wired zero, so a write to it is never a real producer.
    assign ex_hit_o = use_src_i && ex_wr_i  && (src_i == ex_rd_i)  && (ex_rd_i  != '0);
    assign mem_hit  = use_src_i && mem_wr_i && (src_i == mem_rd_i) && (mem_rd_i != '0);
    assign wb_hit   = use_src_i && wb_wr_i  && (src_i == wb_rd_i)  && (wb_rd_i  != '0);

    always_comb begin
        sel_o = FWD_REG;
        // A load in EX has no result yet; the load-use stall handles it,
        // so it must not claim the EX path.
        if (ex_hit_o && !ex_ld_i) begin
            sel_o = FWD_EX;
        end else if (mem_hit) begin
            sel_o = FWD_MEM;
        end else if (wb_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_unit
// Resolves data and control hazards for the 5-stage RISC-V core.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   id_rs1/id_rs2/id_rd      : register fields of the ID-stage instruction
//   id_use_rs1/id_use_rs2    : ID instruction reads rs1/rs2
//   id_reg_write, id_is_load : ID instruction writes rd / is a load
//   ex_br_taken              : branch/jump in EX resolved taken
//   fwd_a_sel/fwd_b_sel      : registered ALU operand forwarding selects
//   stall_if_id              : hold PC and IF/ID
//   bubble_ex                : load a NOP into ID/EX
//   flush_if_id              : invalidate IF/ID
//   stall_cnt                : saturating count of load-use stall cycles
// -----------------------------------------------------------------------------
import pipeline_ctrl_pkg::*;

module pipeline_hazard_unit #(
    parameter int REG_AW       = REG_AW_DEFAULT,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              ex_br_taken,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall_if_id,
    output logic              bubble_ex,
    output logic              flush_if_id,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Flush counter only needs to hold FLUSH_CYCLES-1.
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    hz_state_t          state_q, state_d;
    logic [FC_W-1:0]    fcnt_q, fcnt_d;

    // Stage tracking. The load flag only matters while the producer is in
    // EX (afterwards its data is available), so MEM/WB keep rd and wr only.
    logic [REG_AW-1:0]  ex_rd_q, mem_rd_q, wb_rd_q;
    logic               ex_wr_q, mem_wr_q, wb_wr_q;
    logic               ex_ld_q;

    fwd_sel_t           fwd_a_q, fwd_b_q;
    fwd_sel_t           fwd_a_d, fwd_b_d;
    logic               a_ex_hit, b_ex_hit;
    logic               load_use;

    logic [CNT_W-1:0]   stall_cnt_q;
    logic               cnt_inc;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .src_i     (id_rs1),
        .use_src_i (id_use_rs1),
        .ex_rd_i   (ex_rd_q),
        .ex_wr_i   (ex_wr_q),
        .ex_ld_i   (ex_ld_q),
        .mem_rd_i  (mem_rd_q),
        .mem_wr_i  (mem_wr_q),
        .wb_rd_i   (wb_rd_q),
        .wb_wr_i   (wb_wr_q),
        .ex_hit_o  (a_ex_hit),
        .sel_o     (fwd_a_d)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .src_i     (id_rs2),
        .use_src_i (id_use_rs2),
        .ex_rd_i   (ex_rd_q),
        .ex_wr_i   (ex_wr_q),
        .ex_ld_i   (ex_ld_q),
        .mem_rd_i  (mem_rd_q),
        .mem_wr_i  (mem_wr_q),
        .wb_rd_i   (wb_rd_q),
        .wb_wr_i   (wb_wr_q),
        .ex_hit_o  (b_ex_hit),
        .sel_o     (fwd_b_d)
    );

    assign load_use = (a_ex_hit || b_ex_hit) && ex_ld_q;

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        stall_if_id = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        cnt_inc     = 1'b0;
        case (state_q)
            RUN, LSTALL: begin
                if (ex_br_taken) begin
                    // Taken branch wins over a concurrent load-use; that
                    // stall is never taken and never counted.
                    flush_if_id = 1'b1;
                    bubble_ex   = 1'b1;
                    state_d     = RUN;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
                    end
                end else if (state_q == RUN && load_use) begin
                    stall_if_id = 1'b1;
                    bubble_ex   = 1'b1;
                    cnt_inc     = 1'b1;
                    state_d     = LSTALL;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                // fcnt_q holds the FLUSH cycles remaining, this one included.
                flush_if_id = 1'b1;
                bubble_ex   = 1'b1;
                fcnt_d      = fcnt_q - FC_W'(1);
                if (fcnt_q <= FC_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        // Control outputs are quiet for the whole reset cycle, whatever
        // state is being abandoned.
        if (rst) begin
            stall_if_id = 1'b0;
            bubble_ex   = 1'b0;
            flush_if_id = 1'b0;
            cnt_inc     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            fcnt_q      <= '0;
            ex_rd_q     <= '0;
            ex_wr_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            mem_rd_q    <= '0;
            mem_wr_q    <= 1'b0;
            wb_rd_q     <= '0;
            wb_wr_q     <= 1'b0;
            fwd_a_q     <= FWD_REG;
            fwd_b_q     <= FWD_REG;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;

            if (bubble_ex) begin
                ex_rd_q <= '0;
                ex_wr_q <= 1'b0;
                ex_ld_q <= 1'b0;
            end else begin
                ex_rd_q <= id_rd;
                ex_wr_q <= id_reg_write;
                ex_ld_q <= id_is_load;
            end
            mem_rd_q <= ex_rd_q;
            mem_wr_q <= ex_wr_q;
            wb_rd_q  <= mem_rd_q;
            wb_wr_q  <= mem_wr_q;

            // A flushed instruction enters EX as a NOP, so its selects are
            // cleared; a stalled one keeps the selects it already has.
            if (flush_if_id) begin
                fwd_a_q <= FWD_REG;
                fwd_b_q <= FWD_REG;
            end else if (!stall_if_id) begin
                fwd_a_q <= fwd_a_d;
                fwd_b_q <= fwd_b_d;
            end

            if (cnt_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_unit
// Directed vectors with hand-computed expectations. Two instances share the
// stimulus: the default configuration, and one with FLUSH_CYCLES=1 and a
// 4-bit stall counter so saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, wr, ld, br;

    logic [1:0]  m_fwd_a, m_fwd_b;
    logic        m_stall, m_bubble, m_flush;
    logic [15:0] m_cnt;

    logic [1:0]  s_fwd_a, s_fwd_b;
    logic        s_stall, s_bubble, s_flush;
    logic [3:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_unit dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (rs1),
        .id_rs2       (rs2),
        .id_rd        (rd),
        .id_use_rs1   (u1),
        .id_use_rs2   (u2),
        .id_reg_write (wr),
        .id_is_load   (ld),
        .ex_br_taken  (br),
        .fwd_a_sel    (m_fwd_a),
        .fwd_b_sel    (m_fwd_b),
        .stall_if_id  (m_stall),
        .bubble_ex    (m_bubble),
        .flush_if_id  (m_flush),
        .stall_cnt    (m_cnt)
    );

    pipeline_hazard_unit #(
        .REG_AW       (5),
        .FLUSH_CYCLES (1),
        .CNT_W        (4)
    ) dut_s (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (rs1),
        .id_rs2       (rs2),
        .id_rd        (rd),
        .id_use_rs1   (u1),
        .id_use_rs2   (u2),
        .id_reg_write (wr),
        .id_is_load   (ld),
        .ex_br_taken  (br),
        .fwd_a_sel    (s_fwd_a),
        .fwd_b_sel    (s_fwd_b),
        .stall_if_id  (s_stall),
        .bubble_ex    (s_bubble),
        .flush_if_id  (s_flush),
        .stall_cnt    (s_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                         input logic a1, input logic a2, input logic w,
                         input logic l, input logic b);
        rs1 = r1; rs2 = r2; rd = d;
        u1 = a1; u2 = a2; wr = w; ld = l; br = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
    endtask

    // lw x6 into EX, then a reader of x6: one load-use stall plus LSTALL.
    task automatic do_stall();
        drive(5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(5'd0, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("rst_stall",  32'(m_stall),  0);
        check("rst_bubble", 32'(m_bubble), 0);
        check("rst_flush",  32'(m_flush),  0);
        tick();
        rst = 1'b0;
        check("rst_fwd_a", 32'(m_fwd_a), 0);
        check("rst_fwd_b", 32'(m_fwd_b), 0);
        check("rst_cnt",   32'(m_cnt),   0);

        // ---------------- EX forward to A ----------------
        drive(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);   // add x5
        tick();
        drive(5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // reads x5
        #1;
        check("exfwd_stall", 32'(m_stall), 0);
        tick();
        check("exfwd_a",   32'(m_fwd_a), 1);
        check("exfwd_b",   32'(m_fwd_b), 0);
        check("exfwd_cnt", 32'(m_cnt),   0);
        drain();

        // ---------------- load-use on rs2 ----------------
        drive(5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);   // lw x6
        tick();
        drive(5'd0, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);   // add rs2=x6
        #1;
        check("lu_stall",  32'(m_stall),  1);
        check("lu_bubble", 32'(m_bubble), 1);
        check("lu_flush",  32'(m_flush),  0);
        tick();                                                   // LSTALL
        check("lst_stall",  32'(m_stall),  0);
        check("lst_bubble", 32'(m_bubble), 0);
        check("lst_cnt",    32'(m_cnt),    1);
        tick();                                                   // add in EX
        check("lu_fwd_b", 32'(m_fwd_b), 2);
        check("lu_fwd_a", 32'(m_fwd_a), 0);
        drain();

        // ---------------- priority EX > MEM > WB ----------------
        drive(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();                                                   // EX=x7 MEM=x8 WB=x7
        drive(5'd7, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("prio_stall", 32'(m_stall), 0);
        tick();
        check("prio_a_ex", 32'(m_fwd_a), 1);
        check("prio_b_ex", 32'(m_fwd_b), 1);
        drive(5'd7, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);   // MEM=x7 WB=x8
        tick();
        check("prio_a_mem", 32'(m_fwd_a), 2);
        check("prio_b_wb",  32'(m_fwd_b), 3);
        drain();

        // ---------------- x0 never matches ----------------
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);   // lw x0
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("x0_stall",  32'(m_stall),  0);
        check("x0_bubble", 32'(m_bubble), 0);
        tick();
        check("x0_fwd_a", 32'(m_fwd_a), 0);
        check("x0_fwd_b", 32'(m_fwd_b), 0);
        drain();

        // ---------------- branch beats load-use ----------------
        drive(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);   // lw x9
        tick();
        drive(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);   // reader + taken
        #1;
        check("br1_flush",   32'(m_flush),  1);
        check("br1_bubble",  32'(m_bubble), 1);
        check("br1_stall",   32'(m_stall),  0);
        check("br1_s_flush", 32'(s_flush),  1);
        check("br1_s_stall", 32'(s_stall),  0);
        tick();
        drive(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);   // taken again
        #1;
        check("br2_flush",   32'(m_flush),  1);
        check("br2_bubble",  32'(m_bubble), 1);
        check("br2_stall",   32'(m_stall),  0);
        check("br2_cnt",     32'(m_cnt),    1);
        check("br2_s_flush", 32'(s_flush),  1);
        check("br2_s_cnt",   32'(s_cnt),    1);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("br3_flush",   32'(m_flush),  0);
        check("br3_bubble",  32'(m_bubble), 0);
        check("br3_cnt",     32'(m_cnt),    1);
        check("br3_fwd_a",   32'(m_fwd_a),  0);
        check("br3_s_flush", 32'(s_flush),  0);
        drain();

        // ---------------- reset during LSTALL ----------------
        drive(5'd0, 5'd0, 5'd10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);  // lw x10
        tick();
        drive(5'd10, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("rl_lu_stall", 32'(m_stall), 1);
        tick();                                                   // LSTALL
        rst = 1'b1;
        #1;
        check("rl_stall",  32'(m_stall),  0);
        check("rl_bubble", 32'(m_bubble), 0);
        check("rl_flush",  32'(m_flush),  0);
        tick();
        check("rl_cnt",   32'(m_cnt),   0);
        check("rl_fwd_a", 32'(m_fwd_a), 0);
        check("rl_s_cnt", 32'(s_cnt),   0);
        rst = 1'b0;
        drive(5'd10, 5'd10, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("rl_post_stall", 32'(m_stall), 0);
        tick();
        check("rl_post_fwd_a", 32'(m_fwd_a), 0);
        check("rl_post_fwd_b", 32'(m_fwd_b), 0);
        drain();

        // ---------------- counter saturation ----------------
        for (int i = 0; i < 14; i++) begin
            do_stall();
        end
        check("sat14_s_cnt", 32'(s_cnt), 14);
        check("sat14_m_cnt", 32'(m_cnt), 14);
        for (int i = 0; i < 6; i++) begin
            do_stall();
        end
        check("sat20_s_cnt", 32'(s_cnt), 15);
        check("sat20_m_cnt", 32'(m_cnt), 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
